// File: rtl/systolic_tile_sequencer_if.sv
// systolic_tile_sequencer_if: control/config/status bundle between a tile
// controller (master) and the systolic_tile_sequencer (slave).
// Every request output is a single-cycle strobe: a request is taken by the
// buffers in the cycle it is high, and there is no back-pressure on requests.
// The only flow control is the sequencer-side `stall` input, which holds off
// issue in the cycle it is high.
interface systolic_tile_sequencer_if #(
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16,
  parameter int LOOP_WIDTH      = 16
);
  logic                       start;
  logic                       stall;
  logic [LOOP_WIDTH-1:0]      cfg_num_rows;
  logic [LOOP_WIDTH-1:0]      cfg_num_passes;
  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base;
  logic [BBUF_ADDR_WIDTH-1:0] cfg_bias_base;
  logic                       busy;
  logic                       done;
  logic                       acc_clear;
  logic                       ibuf_read_req;
  logic                       bias_read_req;
  logic [BBUF_ADDR_WIDTH-1:0] bias_read_addr;
  logic                       bias_prev_sw;
  logic                       obuf_read_req;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_read_addr;
  logic                       obuf_write_req;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr;
  logic [31:0]                perf_stall_cycles;
  logic [31:0]                perf_hazard_cycles;

  modport master (
    output start, stall, cfg_num_rows, cfg_num_passes, cfg_obuf_base, cfg_bias_base,
    input  busy, done, acc_clear, ibuf_read_req, bias_read_req, bias_read_addr,
           bias_prev_sw, obuf_read_req, obuf_read_addr, obuf_write_req,
           obuf_write_addr, perf_stall_cycles, perf_hazard_cycles
  );

  modport slave (
    input  start, stall, cfg_num_rows, cfg_num_passes, cfg_obuf_base, cfg_bias_base,
    output busy, done, acc_clear, ibuf_read_req, bias_read_req, bias_read_addr,
           bias_prev_sw, obuf_read_req, obuf_read_addr, obuf_write_req,
           obuf_write_addr, perf_stall_cycles, perf_hazard_cycles
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: tile-level FSM driving the systolic_array datapath.
// Issues rows row-major over (pass, row); pass 0 takes bias, later passes read
// back obuf partial sums. A fixed-latency delay line produces obuf writes and
// an interlock blocks a pass-p read until the pass-(p-1) write has landed.
// Optional feature macro: SYS_SEQ_PERF_EN builds the stall/hazard perf counters.
module systolic_tile_sequencer #(
  parameter int OBUF_ADDR_WIDTH = 16,
  parameter int BBUF_ADDR_WIDTH = 16,
  parameter int LOOP_WIDTH      = 16,
  parameter int PIPE_LATENCY    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  systolic_tile_sequencer_if.slave bus,
  output logic [2:0]              o_dbg_state
);
  localparam int CW = 2 * LOOP_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next_state;

  logic [LOOP_WIDTH-1:0]      r_rows, r_passes, r_row, r_pass;
  logic [OBUF_ADDR_WIDTH-1:0] r_obuf_base;
  logic [BBUF_ADDR_WIDTH-1:0] r_bias_base;
  logic [CW-1:0]              r_issue_cnt, r_wr_cnt;
  logic [PIPE_LATENCY-1:0]    r_pipe_vld;
  logic [OBUF_ADDR_WIDTH-1:0] r_pipe_addr [PIPE_LATENCY];

  logic                       w_start_ok, w_zero_tile, w_hazard, w_issue;
  logic                       w_row_last, w_pass_last, w_last_issue;
  logic                       w_wr_now, w_drain_empty;
  logic [CW:0]                w_wr_plus_rows;
  logic [CW-1:0]              w_inflight;
  logic [OBUF_ADDR_WIDTH-1:0] w_obuf_row_addr;
  logic [BBUF_ADDR_WIDTH-1:0] w_bias_row_addr;

  assign w_zero_tile    = (bus.cfg_num_rows == '0) || (bus.cfg_num_passes == '0);
  // Issue i (pass >= 1) depends on write i-R: allowed once writes > i-R,
  // rearranged as writes + R > i so nothing underflows.
  assign w_wr_plus_rows = {1'b0, r_wr_cnt} + (CW+1)'(r_rows);
  assign w_hazard       = (r_pass != '0) && (w_wr_plus_rows <= {1'b0, r_issue_cnt});
  assign w_issue        = (r_state == S_ISSUE) && !bus.stall && !w_hazard;
  assign w_row_last     = (r_row == r_rows - LOOP_WIDTH'(1));
  assign w_pass_last    = (r_pass == r_passes - LOOP_WIDTH'(1));
  assign w_last_issue   = w_issue && w_row_last && w_pass_last;
  assign w_wr_now       = r_pipe_vld[PIPE_LATENCY-1];
  // Issues minus completed writes = rows still inside the delay line.
  assign w_inflight     = r_issue_cnt - r_wr_cnt;
  // Drain ends when the only outstanding write is the one leaving this cycle.
  assign w_drain_empty  = (w_inflight == CW'(w_wr_now));
  assign w_obuf_row_addr = r_obuf_base + OBUF_ADDR_WIDTH'(r_row);
  assign w_bias_row_addr = r_bias_base + BBUF_ADDR_WIDTH'(r_row);

  // Next-state logic; start is honoured only from IDLE.
  always_comb begin
    w_next_state = r_state;
    w_start_ok   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_ok   = 1'b1;
          w_next_state = w_zero_tile ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: w_next_state = S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next_state = S_DRAIN;
      S_DRAIN: if (w_drain_empty) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, latched tile config and row/pass/issue/write counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rows      <= '0;
      r_passes    <= '0;
      r_obuf_base <= '0;
      r_bias_base <= '0;
      r_row       <= '0;
      r_pass      <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start_ok) begin
        r_rows      <= bus.cfg_num_rows;
        r_passes    <= bus.cfg_num_passes;
        r_obuf_base <= bus.cfg_obuf_base;
        r_bias_base <= bus.cfg_bias_base;
        r_row       <= '0;
        r_pass      <= '0;
        r_issue_cnt <= '0;
        r_wr_cnt    <= '0;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + CW'(1);
          if (w_row_last) begin
            r_row  <= '0;
            r_pass <= r_pass + LOOP_WIDTH'(1);
          end else begin
            r_row  <= r_row + LOOP_WIDTH'(1);
          end
        end
        if (w_wr_now) r_wr_cnt <= r_wr_cnt + CW'(1);
      end
    end
  end

  // Write delay line: one slot per cycle of latency; shifts every cycle, ignores stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < PIPE_LATENCY; k++) r_pipe_addr[k] <= '0;
    end else begin
      r_pipe_vld     <= {r_pipe_vld[PIPE_LATENCY-2:0], w_issue};
      r_pipe_addr[0] <= w_issue ? w_obuf_row_addr : '0;
      for (int k = 1; k < PIPE_LATENCY; k++) r_pipe_addr[k] <= r_pipe_addr[k-1];
    end
  end

  assign o_dbg_state         = r_state;
  assign bus.busy            = (r_state == S_CLEAR) || (r_state == S_ISSUE) ||
                               (r_state == S_DRAIN) || (w_inflight != '0);
  assign bus.done            = (r_state == S_DONE);
  assign bus.acc_clear       = (r_state == S_CLEAR);
  assign bus.ibuf_read_req   = w_issue;
  assign bus.bias_read_req   = w_issue && (r_pass == '0);
  assign bus.bias_prev_sw    = w_issue && (r_pass == '0);
  assign bus.bias_read_addr  = (w_issue && (r_pass == '0)) ? w_bias_row_addr : '0;
  assign bus.obuf_read_req   = w_issue && (r_pass != '0);
  assign bus.obuf_read_addr  = (w_issue && (r_pass != '0)) ? w_obuf_row_addr : '0;
  assign bus.obuf_write_req  = w_wr_now;
  assign bus.obuf_write_addr = r_pipe_addr[PIPE_LATENCY-1];

`ifdef SYS_SEQ_PERF_EN
  logic [31:0] r_perf_stall, r_perf_hazard;

  // Saturating counts of ISSUE cycles lost to stall (priority) or interlock.
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_perf_stall  <= '0;
      r_perf_hazard <= '0;
    end else if (r_state == S_ISSUE) begin
      if (bus.stall) begin
        if (r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      end else if (w_hazard) begin
        if (r_perf_hazard != '1) r_perf_hazard <= r_perf_hazard + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cycles  = r_perf_stall;
  assign bus.perf_hazard_cycles = r_perf_hazard;
`else
  assign bus.perf_stall_cycles  = '0;
  assign bus.perf_hazard_cycles = '0;
`endif
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb_systolic_tile_sequencer: directed tiles against an issue-schedule model.
module tb_systolic_tile_sequencer;
  localparam int LAT  = 10;
  localparam int MAXC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  systolic_tile_sequencer_if #(.OBUF_ADDR_WIDTH(16), .BBUF_ADDR_WIDTH(16), .LOOP_WIDTH(16)) bus_if ();

  systolic_tile_sequencer #(
    .OBUF_ADDR_WIDTH(16), .BBUF_ADDR_WIDTH(16), .LOOP_WIDTH(16), .PIPE_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus tables ----------------
  bit start_tbl [MAXC];
  bit stall_tbl [MAXC];
  bit rst_tbl   [MAXC];

  // ---------------- model outputs ----------------
  bit          e_clear[MAXC], e_ibuf[MAXC], e_breq[MAXC], e_sw[MAXC];
  bit          e_oreq[MAXC], e_wreq[MAXC], e_done[MAXC], e_busy[MAXC];
  logic [15:0] e_baddr[MAXC], e_oaddr[MAXC], e_waddr[MAXC];
  logic [15:0] exp_q[$];
  int          m_stall, m_haz, m_done, m_len, m_icyc0, m_icyc_pass1;

  // ---------------- scoreboard state ----------------
  int    total = 0;
  int    bad   = 0;
  bit    chk_en = 1'b0;
  int    cur_t = 0;
  string tname = "init";

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_tbls();
    for (int t = 0; t < MAXC; t++) begin
      start_tbl[t] = 1'b0;
      stall_tbl[t] = 1'b0;
      rst_tbl[t]   = 1'b0;
    end
    start_tbl[0] = 1'b1;
  endtask

  // Schedule model: each issue index i lands in the first cycle that is in
  // ISSUE, not stalled, and (pass>0) strictly after write i-R has happened.
  task automatic build_model(input int rows, input int passes,
                             input logic [15:0] ob, input logic [15:0] bb,
                             input int rst_at);
    int c, n, r, p;
    int icyc[MAXC];
    for (int t = 0; t < MAXC; t++) begin
      e_clear[t] = 0; e_ibuf[t] = 0; e_breq[t] = 0; e_sw[t] = 0;
      e_oreq[t] = 0; e_wreq[t] = 0; e_done[t] = 0; e_busy[t] = 0;
      e_baddr[t] = '0; e_oaddr[t] = '0; e_waddr[t] = '0;
      icyc[t] = 0;
    end
    exp_q.delete();
    m_stall = 0; m_haz = 0; m_icyc0 = -1; m_icyc_pass1 = -1;
    if (rows == 0 || passes == 0) begin
      e_done[1] = 1;
      m_done = 1;
    end else begin
      e_clear[1] = 1;
      c = 2;
      n = rows * passes;
      for (int i = 0; i < n; i++) begin
        r = i % rows;
        p = i / rows;
        while (1) begin
          if (stall_tbl[c]) begin m_stall++; c++; end
          else if (p > 0 && c <= icyc[i-rows] + LAT) begin m_haz++; c++; end
          else break;
        end
        icyc[i] = c;
        e_ibuf[c] = 1;
        if (p == 0) begin e_breq[c] = 1; e_sw[c] = 1; e_baddr[c] = bb + 16'(r); end
        else begin e_oreq[c] = 1; e_oaddr[c] = ob + 16'(r); end
        e_wreq[c+LAT]  = 1;
        e_waddr[c+LAT] = ob + 16'(r);
        c++;
      end
      m_done = icyc[n-1] + LAT + 1;
      for (int t = 1; t < m_done; t++) e_busy[t] = 1;
      e_done[m_done] = 1;
      m_icyc0 = icyc[0];
      if (passes > 1) m_icyc_pass1 = icyc[rows];
    end
    if (rst_at >= 0) begin
      for (int t = rst_at + 1; t < MAXC; t++) begin
        e_clear[t] = 0; e_ibuf[t] = 0; e_breq[t] = 0; e_sw[t] = 0;
        e_oreq[t] = 0; e_wreq[t] = 0; e_done[t] = 0; e_busy[t] = 0;
        e_baddr[t] = '0; e_oaddr[t] = '0; e_waddr[t] = '0;
      end
      m_stall = 0;
      m_haz   = 0;
    end
    for (int t = 0; t < MAXC; t++) if (e_wreq[t]) exp_q.push_back(e_waddr[t]);
    m_len = (m_done + 4 > 24) ? m_done + 4 : 24;
  endtask

  // ---------------- driver ----------------
  task automatic run_tile(input string name, input int rows, input int passes,
                          input logic [15:0] ob, input logic [15:0] bb);
    tname = name;
    bus_if.cfg_num_rows   = 16'(rows);
    bus_if.cfg_num_passes = 16'(passes);
    bus_if.cfg_obuf_base  = ob;
    bus_if.cfg_bias_base  = bb;
    for (int t = 0; t < m_len; t++) begin
      @(negedge clk);
      reset        = rst_tbl[t];
      bus_if.start = start_tbl[t];
      bus_if.stall = stall_tbl[t];
      cur_t        = t;
      chk_en       = 1'b1;
    end
    @(negedge clk);
    chk_en       = 1'b0;
    reset        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.stall = 1'b0;
    check({name, " leftover_writes"}, exp_q.size(), 0);
`ifdef SYS_SEQ_PERF_EN
    check({name, " perf_stall"},  bus_if.perf_stall_cycles,  m_stall);
    check({name, " perf_hazard"}, bus_if.perf_hazard_cycles, m_haz);
`else
    check({name, " perf_stall"},  bus_if.perf_stall_cycles,  0);
    check({name, " perf_hazard"}, bus_if.perf_hazard_cycles, 0);
`endif
  endtask

  // ---------------- compare process ----------------
  logic [55:0] act_v, exp_v;
  logic [15:0] q_addr;
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      act_v = {bus_if.acc_clear, bus_if.ibuf_read_req, bus_if.bias_read_req,
               bus_if.bias_prev_sw, bus_if.obuf_read_req, bus_if.obuf_write_req,
               bus_if.done, bus_if.busy, bus_if.bias_read_addr,
               bus_if.obuf_read_addr, bus_if.obuf_write_addr};
      exp_v = {e_clear[cur_t], e_ibuf[cur_t], e_breq[cur_t], e_sw[cur_t],
               e_oreq[cur_t], e_wreq[cur_t], e_done[cur_t], e_busy[cur_t],
               e_baddr[cur_t], e_oaddr[cur_t], e_waddr[cur_t]};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d outputs: got %h want %h", tname, cur_t, act_v, exp_v);
      end
      if (bus_if.obuf_write_req === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s cycle %0d write: got addr %h want no write", tname, cur_t,
                   bus_if.obuf_write_addr);
        end else begin
          q_addr = exp_q.pop_front();
          if (bus_if.obuf_write_addr !== q_addr) begin
            bad++;
            $display("FAIL %s cycle %0d write_addr: got %h want %h", tname, cur_t,
                     bus_if.obuf_write_addr, q_addr);
          end
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    bus_if.start = 1'b0;
    bus_if.stall = 1'b0;
    bus_if.cfg_num_rows   = '0;
    bus_if.cfg_num_passes = '0;
    bus_if.cfg_obuf_base  = '0;
    bus_if.cfg_bias_base  = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset outputs",
          {bus_if.busy, bus_if.done, bus_if.acc_clear, bus_if.ibuf_read_req,
           bus_if.bias_read_req, bus_if.bias_prev_sw, bus_if.obuf_read_req,
           bus_if.obuf_write_req, bus_if.bias_read_addr, bus_if.obuf_read_addr,
           bus_if.obuf_write_addr}, 0);
    check("reset perf", {bus_if.perf_stall_cycles, bus_if.perf_hazard_cycles}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // R=4 P=1 basic
    clear_tbls();
    build_model(4, 1, 16'h0020, 16'h0010, -1);
    check("pin t1 first_issue", m_icyc0, 2);
    check("pin t1 done_cycle", m_done, 16);
    run_tile("t1_r4p1", 4, 1, 16'h0020, 16'h0010);

    // R=12 P=2 contiguous, no hazard
    clear_tbls();
    build_model(12, 2, 16'h0020, 16'h0010, -1);
    check("pin t2 pass1_issue", m_icyc_pass1, 14);
    check("pin t2 hazard", m_haz, 0);
    check("pin t2 done_cycle", m_done, 36);
    run_tile("t2_r12p2", 12, 2, 16'h0020, 16'h0010);

    // R=2 P=2 hazard interlock
    clear_tbls();
    build_model(2, 2, 16'h0020, 16'h0010, -1);
    check("pin t3 pass1_issue", m_icyc_pass1, 13);
    check("pin t3 hazard", m_haz, 9);
    check("pin t3 done_cycle", m_done, 25);
    run_tile("t3_r2p2_hazard", 2, 2, 16'h0020, 16'h0010);

    // R=4 P=1 stall in cycles 3-4
    clear_tbls();
    stall_tbl[3] = 1'b1;
    stall_tbl[4] = 1'b1;
    build_model(4, 1, 16'h0020, 16'h0010, -1);
    check("pin t4 stall", m_stall, 2);
    check("pin t4 done_cycle", m_done, 18);
    run_tile("t4_stall", 4, 1, 16'h0020, 16'h0010);

    // R=0: immediate done
    clear_tbls();
    build_model(0, 3, 16'h0020, 16'h0010, -1);
    check("pin t5 done_cycle", m_done, 1);
    run_tile("t5_r0", 0, 3, 16'h0020, 16'h0010);

    // start pulsed while busy (ISSUE and DONE) is ignored
    clear_tbls();
    start_tbl[5]  = 1'b1;
    start_tbl[16] = 1'b1;
    build_model(4, 1, 16'h0020, 16'h0010, -1);
    run_tile("t6_start_busy", 4, 1, 16'h0020, 16'h0010);

    // reset in cycle 8 of the first tile, then a fresh tile
    clear_tbls();
    rst_tbl[8] = 1'b1;
    build_model(4, 1, 16'h0020, 16'h0010, 8);
    check("pin t7 writes_left", exp_q.size(), 0);
    run_tile("t7_reset_mid", 4, 1, 16'h0020, 16'h0010);
    clear_tbls();
    build_model(4, 1, 16'h0020, 16'h0010, -1);
    run_tile("t7b_after_reset", 4, 1, 16'h0020, 16'h0010);

    // address wrap on both buffers
    clear_tbls();
    build_model(3, 2, 16'hFFFF, 16'hFFFE, -1);
    check("pin t8 pass1_issue", m_icyc_pass1, 13);
    run_tile("t8_wrap", 3, 2, 16'hFFFF, 16'hFFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
